// File: rtl/cla_64_adder_if.sv
// Operand/result bundle for the 64-bit look-ahead adder.
// The master drives the operands and the slave (the adder) returns registered results.
interface cla_64_adder_if;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [63:0] sum;
  logic        cout;
  logic        gout;
  logic        pout;

  modport master (output a, b, cin, input sum, cout, gout, pout);
  modport slave  (input a, b, cin, output sum, cout, gout, pout);
endinterface

// File: rtl/cla_64_adder.sv
// 64-bit three-level carry look-ahead adder (4-bit cells, 16-bit and 64-bit groups).
// The sum, carry-out and top-level group G/P are captured in an output register.
module cla_64_adder (
  input  logic           clk,
  input  logic           rst,
  cla_64_adder_if.slave  bus
);

  // Carries into positions 0..3 of a 4-wide look-ahead block; position 0 is ci itself.
  function automatic logic [3:0] la_carry(input logic [2:0] g, input logic [2:0] p,
                                          input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Group {P, G} of a 4-wide block.
  function automatic logic [1:0] la_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    logic pp;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp = &p;
    return {pp, gg};
  endfunction

  logic [63:0] bit_g;
  logic [63:0] bit_p;
  logic [63:0] bit_c;
  logic [15:0] cell_g;
  logic [15:0] cell_p;
  logic [15:0] cell_cin;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_cin;
  logic        top_g;
  logic        top_p;

  logic [63:0] sum_next;
  logic        cout_next;
  logic [63:0] sum_reg;
  logic        cout_reg;
  logic        gout_reg;
  logic        pout_reg;

  assign bit_g = bus.a & bus.b;
  assign bit_p = bus.a ^ bus.b;

  genvar gi;

  // 4-bit cells: G/P depend only on the operands, carries come down from the 16-bit level.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cell
      assign {cell_p[gi], cell_g[gi]} = la_gp(bit_g[4*gi +: 4], bit_p[4*gi +: 4]);
      assign bit_c[4*gi +: 4] = la_carry(bit_g[4*gi +: 3], bit_p[4*gi +: 3], cell_cin[gi]);
    end
  endgenerate

  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp16
      assign {grp_p[gi], grp_g[gi]} = la_gp(cell_g[4*gi +: 4], cell_p[4*gi +: 4]);
      assign cell_cin[4*gi +: 4] = la_carry(cell_g[4*gi +: 3], cell_p[4*gi +: 3], grp_cin[gi]);
    end
  endgenerate

  // Top level resolves c16/c32/c48 directly from cin; no ripple between groups.
  assign {top_p, top_g} = la_gp(grp_g, grp_p);
  assign grp_cin        = la_carry(grp_g[2:0], grp_p[2:0], bus.cin);

  assign sum_next  = bit_p ^ bit_c;
  assign cout_next = top_g | (top_p & bus.cin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg  <= 64'd0;
      cout_reg <= 1'b0;
      gout_reg <= 1'b0;
      pout_reg <= 1'b0;
    end else begin
      sum_reg  <= sum_next;
      cout_reg <= cout_next;
      gout_reg <= top_g;
      pout_reg <= top_p;
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.gout = gout_reg;
  assign bus.pout = pout_reg;

endmodule

// File: tb/tb_cla_64_adder.sv
// Directed and random checks of the registered 64-bit look-ahead adder,
// including one-cycle latency and asynchronous reset behaviour.
module tb_cla_64_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_64_adder_if bus ();

  cla_64_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] es, input logic ec,
                         input logic eg, input logic ep);
    chk({tag, ".sum"},  bus.sum,         es);
    chk({tag, ".cout"}, {63'd0, bus.cout}, {63'd0, ec});
    chk({tag, ".gout"}, {63'd0, bus.gout}, {63'd0, eg});
    chk({tag, ".pout"}, {63'd0, bus.pout}, {63'd0, ep});
    $display("txn %s a=%h b=%h cin=%0d -> sum=%h cout=%0d g=%0d p=%0d",
             tag, bus.a, bus.b, bus.cin, bus.sum, bus.cout, bus.gout, bus.pout);
  endtask

  task automatic apply(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic [63:0] es, input logic ec,
                       input logic eg, input logic ep);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.cin = ci;
    @(posedge clk);
    #1;
    chk_all(tag, es, ec, eg, ep);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] full;
    logic [64:0] gfull;

    rst     = 1'b1;
    bus.a   = 64'd0;
    bus.b   = 64'd0;
    bus.cin = 1'b0;
    #2;
    chk_all("reset_initial", 64'd0, 1'b0, 1'b0, 1'b0);

    // Reset held across edges with live operands keeps outputs at zero.
    bus.a   = ONES;
    bus.b   = ONES;
    bus.cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    apply("max_plus_max", ONES, ONES, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0);
    apply("full_prop",    ONES, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
    apply("cross_cell",   64'h0000_0000_0000_000F, 64'd1, 1'b0,
          64'h0000_0000_0000_0010, 1'b0, 1'b0, 1'b0);
    apply("cross_16",     64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    apply("cross_32",     64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
          64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    apply("cross_48",     64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    apply("msb_gen",      64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
          64'd0, 1'b1, 1'b1, 1'b0);
    apply("alt_nocin",    64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
          ONES, 1'b0, 1'b0, 1'b1);
    apply("alt_cin",      64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1,
          64'd0, 1'b1, 1'b0, 1'b1);
    apply("zero_cin",     64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);

    // Mid-cycle input change must not reach the outputs before the next edge.
    apply("hold_base", 64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0);
    #2;
    bus.a = 64'd100;
    bus.b = 64'd200;
    #1;
    chk("hold_midcycle.sum", bus.sum, 64'd3);
    @(posedge clk);
    #1;
    chk("hold_next_edge.sum", bus.sum, 64'd300);

    // Reset between edges clears immediately and discards the pending result.
    apply("pre_reset", ONES, ONES, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("reset_async", 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reset_edge", 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("release_no_edge", 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("release_first", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra    = {$urandom(), $urandom()};
      rb    = {$urandom(), $urandom()};
      rc    = 1'($urandom_range(0, 1));
      full  = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      gfull = {1'b0, ra} + {1'b0, rb};
      apply($sformatf("rand%0d", i), ra, rb, rc, full[63:0], full[64], gfull[64], &(ra ^ rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
